mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client (IFU, LSU) arbiter in front of a single data-memory
// port. One transaction in flight at a time; round-robin between the clients
// when both request together. Illegal LSU accesses are answered locally with
// an error, and a stalled memory is answered with an error after
// TIMEOUT_CYCLES cycles spent waiting for the completion.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ifu_req_valid/ready      IFU fetch handshake, ifu_addr = fetch address
//   ifu_resp_valid           one-cycle IFU response pulse
//   lsu_req_valid/ready      LSU handshake with lsu_addr/wen/memop/wdata
//   lsu_resp_valid           one-cycle LSU response pulse
//   resp_rdata, resp_err     response payload, held until the next response
//   mem_req_valid/ready      downstream request handshake
//   mem_addr/wen/memop/wdata downstream request fields (stable while valid)
//   mem_resp_valid, mem_rdata downstream completion and load data
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [2:0]  lsu_memop,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [2:0]  mem_memop,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        last_lsu;   // 1: LSU was the most recent grantee
  logic        owner_lsu;  // grantee of the transaction in flight
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        wen_q, err_q;
  logic [2:0]  memop_q;
  logic [15:0] wait_cnt;
  logic        grant_lsu, accept, lsu_illegal, wait_expired;

  // Grant choice, meaningful only while some request is valid in IDLE.
  always_comb begin
    grant_lsu = lsu_req_valid;
    if (ifu_req_valid && lsu_req_valid) grant_lsu = ~last_lsu;
  end

  assign accept       = (state == IDLE) && !rst && (ifu_req_valid || lsu_req_valid);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Halfwords may sit at any offset except one crossing the word boundary;
  // unsigned variants are load-only.
  always_comb begin
    lsu_illegal = 1'b1;
    case (lsu_memop)
      3'b000:  lsu_illegal = 1'b0;
      3'b001:  lsu_illegal = (lsu_addr[1:0] == 2'b11);
      3'b010:  lsu_illegal = (lsu_addr[1:0] != 2'b00);
      3'b100:  lsu_illegal = lsu_wen;
      3'b101:  lsu_illegal = lsu_wen || (lsu_addr[1:0] == 2'b11);
      default: lsu_illegal = 1'b1;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_lsu  <= 1'b0;
      owner_lsu <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      memop_q   <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          owner_lsu <= grant_lsu;
          wait_cnt  <= '0;
          if (grant_lsu) begin
            addr_q  <= lsu_addr;
            wen_q   <= lsu_wen;
            memop_q <= lsu_memop;
            wdata_q <= lsu_wdata;
            if (lsu_illegal) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end else begin
            addr_q  <= ifu_addr;
            wen_q   <= 1'b0;
            memop_q <= 3'b010;
            wdata_q <= '0;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (mem_resp_valid) begin
            rdata_q <= wen_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (wait_expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: last_lsu <= owner_lsu;
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (grant_lsu && lsu_illegal) ? RESP : ISSUE;
      ISSUE:   if (mem_req_ready) state_nxt = WAIT;
      WAIT:    if (mem_resp_valid || wait_expired) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; handshake/pulse outputs are forced low while rst is asserted.
  always_comb begin
    ifu_req_ready  = accept && !grant_lsu;
    lsu_req_ready  = accept && grant_lsu;
    mem_req_valid  = (state == ISSUE) && !rst;
    ifu_resp_valid = (state == RESP) && !rst && !owner_lsu;
    lsu_resp_valid = (state == RESP) && !rst && owner_lsu;
    mem_addr       = addr_q;
    mem_wen        = wen_q;
    mem_memop      = memop_q;
    mem_wdata      = wdata_q;
    resp_rdata     = rdata_q;
    resp_err       = err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [2:0]  lsu_memop;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_memop;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_memop(lsu_memop),
    .lsu_wdata(lsu_wdata), .lsu_resp_valid(lsu_resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_memop(mem_memop),
    .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state: last grantee and the most recent response payload.
  bit          last_lsu_m;
  logic [31:0] exp_rdata_m;
  bit          exp_err_m;
  bit          use_fix;
  logic [31:0] fix_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Legal set of MemOps, loads-only unsigned ops, and no access that
  // straddles a 4-byte word.
  function automatic bit illegal_req(input logic we, input logic [2:0] op, input logic [31:0] a);
    int unsigned bytes;
    if (!(op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
    if (we && op[2]) return 1'b1;
    bytes = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    return (a % 4) + bytes > 4;
  endfunction

  // One arbitration round starting from IDLE. Either or both clients raise a
  // request at cycle 0 and hold it until accepted. d1 = ISSUE stall cycles,
  // d2 = WAIT cycle index of the completion (>= TO means none arrives).
  task automatic run_trial(input bit en_i, input bit en_l,
                           input logic [31:0] a_i, input logic [31:0] a_l,
                           input logic we_l, input logic [2:0] op_l, input logic [31:0] wd_l,
                           input int unsigned d1i, input int unsigned d2i,
                           input int unsigned d1l, input int unsigned d2l);
    bit          own [2];
    logic [31:0] ad [2];
    logic        we [2];
    logic [2:0]  op [2];
    bit          ill [2];
    bit          tmo [2];
    int unsigned d1 [2], d2 [2], s [2], r [2];
    logic [31:0] rd [2];
    int unsigned n, last_c, s_i, s_l;
    bit          first_lsu, is_l;
    bit          e_ir, e_lr, e_mv, e_irv, e_lrv;
    logic [31:0] e_ad;
    logic        e_we;
    logic [2:0]  e_op;
    bit          e_lsu_fields;

    first_lsu = en_l && (!en_i || !last_lsu_m);
    n = 0;
    for (int k = 0; k < 2; k++) begin
      is_l = (k == 0) ? first_lsu : !first_lsu;
      if (is_l ? en_l : en_i) begin
        own[n] = is_l;
        ad[n]  = is_l ? a_l : a_i;
        we[n]  = is_l ? we_l : 1'b0;
        op[n]  = is_l ? op_l : 3'b010;
        ill[n] = is_l ? illegal_req(we_l, op_l, a_l) : 1'b0;
        d1[n]  = is_l ? d1l : d1i;
        d2[n]  = is_l ? d2l : d2i;
        tmo[n] = !ill[n] && (d2[n] >= TO);
        s[n]   = (n == 0) ? 0 : r[n-1] + 1;
        if (ill[n])      r[n] = s[n] + 1;
        else if (tmo[n]) r[n] = s[n] + 2 + d1[n] + TO;
        else             r[n] = s[n] + 3 + d1[n] + d2[n];
        rd[n] = '0;
        n++;
      end
    end
    last_c = r[n-1] + 1;
    s_i = 0;
    s_l = 0;
    for (int k = 0; k < 2; k++) begin
      if (k < n && own[k])  s_l = s[k];
      if (k < n && !own[k]) s_i = s[k];
    end

    for (int unsigned c = 0; c <= last_c; c++) begin
      @(negedge clk);
      ifu_req_valid  = en_i && (c <= s_i);
      ifu_addr       = a_i;
      lsu_req_valid  = en_l && (c <= s_l);
      lsu_addr       = a_l;
      lsu_wen        = we_l;
      lsu_memop      = op_l;
      lsu_wdata      = wd_l;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = use_fix ? fix_rdata : $urandom();
      for (int k = 0; k < 2; k++) begin
        if (k < n) begin
          // Stray completions outside WAIT must have no effect.
          if (c == r[k]) mem_resp_valid = 1'($urandom_range(0, 1));
          if (!ill[k]) begin
            if (c >= s[k] + 1 && c <= s[k] + 1 + d1[k]) mem_resp_valid = 1'($urandom_range(0, 1));
            if (c == s[k] + 1 + d1[k]) mem_req_ready = 1'b1;
            if (!tmo[k] && c == s[k] + 2 + d1[k] + d2[k]) begin
              mem_resp_valid = 1'b1;
              rd[k] = we[k] ? '0 : mem_rdata;
            end
          end
        end
      end
      #1;
      e_ir = 0; e_lr = 0; e_mv = 0; e_irv = 0; e_lrv = 0;
      e_ad = '0; e_we = 1'b0; e_op = '0; e_lsu_fields = 0;
      for (int k = 0; k < 2; k++) begin
        if (k < n) begin
          if (c == s[k]) begin
            if (own[k]) e_lr = 1; else e_ir = 1;
          end
          if (!ill[k] && c >= s[k] + 1 && c <= s[k] + 1 + d1[k]) begin
            e_mv = 1; e_ad = ad[k]; e_we = we[k]; e_op = op[k]; e_lsu_fields = own[k];
          end
          if (c == r[k]) begin
            if (own[k]) e_lrv = 1; else e_irv = 1;
            exp_rdata_m = rd[k];
            exp_err_m   = ill[k] || tmo[k];
          end
        end
      end
      check("ifu_req_ready",  ifu_req_ready,  e_ir);
      check("lsu_req_ready",  lsu_req_ready,  e_lr);
      check("mem_req_valid",  mem_req_valid,  e_mv);
      check("ifu_resp_valid", ifu_resp_valid, e_irv);
      check("lsu_resp_valid", lsu_resp_valid, e_lrv);
      check("resp_rdata",     resp_rdata,     exp_rdata_m);
      check("resp_err",       resp_err,       exp_err_m);
      if (e_mv) begin
        check("mem_addr",  mem_addr,  e_ad);
        check("mem_wen",   mem_wen,   e_we);
        check("mem_memop", mem_memop, e_op);
        if (e_lsu_fields) check("mem_wdata", mem_wdata, wd_l);
      end
    end
    last_lsu_m = own[n-1];
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
    ifu_addr = '0; lsu_addr = '0; lsu_wen = 0; lsu_memop = '0; lsu_wdata = '0; mem_rdata = '0;
  endtask

  initial begin
    logic [31:0] ra, rw;
    use_fix = 0;
    fix_rdata = '0;
    idle_inputs();
    // Reset with both clients requesting: nothing may be granted.
    rst = 1;
    ifu_req_valid = 1;
    lsu_req_valid = 1;
    lsu_memop = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_ifu_ready", ifu_req_ready,  1'b0);
      check("rst_lsu_ready", lsu_req_ready,  1'b0);
      check("rst_mem_valid", mem_req_valid,  1'b0);
      check("rst_ifu_resp",  ifu_resp_valid, 1'b0);
      check("rst_lsu_resp",  lsu_resp_valid, 1'b0);
      check("rst_rdata",     resp_rdata,     32'h0);
      check("rst_err",       resp_err,       1'b0);
    end
    @(negedge clk);
    rst = 0;
    idle_inputs();
    last_lsu_m = 0;
    exp_rdata_m = '0;
    exp_err_m = 0;

    // Both valid after reset: LSU first (IFU counts as last grantee), then IFU.
    run_trial(1, 1, 32'h8000_0010, 32'h8000_0100, 1'b0, 3'b010, 32'h0, 0, 0, 1, 2);
    // Minimum-latency IFU fetch.
    use_fix = 1;
    fix_rdata = 32'h0000_0413;
    run_trial(1, 0, 32'h8000_0000, 32'h0, 1'b0, 3'b010, 32'h0, 0, 0, 0, 0);
    use_fix = 0;
    // sh to a word-straddling address: local error response.
    run_trial(0, 1, 32'h0, 32'h8000_0003, 1'b1, 3'b001, 32'h0000_BEEF, 0, 0, 0, 0);
    // Load with no completion: timeout after TO WAIT cycles.
    run_trial(0, 1, 32'h0, 32'h8000_0040, 1'b0, 3'b010, 32'h0, 0, 0, 0, TO + 3);
    // Completion in the last WAIT cycle still counts as success.
    run_trial(0, 1, 32'h0, 32'h8000_0044, 1'b0, 3'b101, 32'h0, 0, 0, 2, TO - 1);

    for (int t = 0; t < 200; t++) begin
      int unsigned sel;
      sel = $urandom_range(1, 3);
      ra = $urandom();
      rw = $urandom();
      run_trial(sel[0], sel[1], {ra[31:2], 2'b00}, rw, 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), $urandom(),
                $urandom_range(0, 3), $urandom_range(0, TO + 1),
                $urandom_range(0, 3), $urandom_range(0, TO + 1));
    end

    // ISSUE stalled 3 cycles, then reset while in WAIT.
    rw = $urandom();
    for (int unsigned c = 0; c <= 8; c++) begin
      @(negedge clk);
      lsu_req_valid  = (c == 0);
      lsu_addr       = 32'h1000_0004;
      lsu_wen        = 1'b1;
      lsu_memop      = 3'b010;
      lsu_wdata      = rw;
      mem_req_ready  = (c == 4);
      mem_resp_valid = (c == 5);
      mem_rdata      = $urandom();
      rst            = (c == 5);
      #1;
      if (c == 0) check("stall_accept", lsu_req_ready, 1'b1);
      if (c >= 1 && c <= 4) begin
        check("stall_valid", mem_req_valid, 1'b1);
        check("stall_addr",  mem_addr,  32'h1000_0004);
        check("stall_wdata", mem_wdata, rw);
        check("stall_memop", mem_memop, 3'b010);
      end
      if (c >= 5) begin
        check("rst_wait_valid", mem_req_valid,  1'b0);
        check("rst_wait_ifu",   ifu_resp_valid, 1'b0);
        check("rst_wait_lsu",   lsu_resp_valid, 1'b0);
      end
      if (c >= 6) begin
        check("rst_wait_rdata", resp_rdata, 32'h0);
        check("rst_wait_err",   resp_err,   1'b0);
      end
    end
    last_lsu_m = 0;
    exp_rdata_m = '0;
    exp_err_m = 0;
    // Last-grant restored to IFU: LSU must win the next tie.
    run_trial(1, 1, 32'h8000_0200, 32'h8000_0300, 1'b0, 3'b000, 32'h0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
